// File: rtl/autosa_mcif_pkg.sv
// Shared constants for the MCIF SDP read responder.
// Request/response payload layout, beat size and credit-width helper.
package autosa_mcif_pkg;

  localparam int REQ_ADDR_LSB = 0;
  localparam int REQ_ADDR_W   = 32;
  localparam int REQ_SIZE_LSB = 32;
  localparam int REQ_SIZE_W   = 15;
  localparam int REQ_PD_W     = 47;

  localparam int DATA_W     = 64;
  localparam int RSP_PD_W   = 65;
  localparam int BEAT_BYTES = 8;
  localparam int BEAT_SH    = $clog2(BEAT_BYTES);

  typedef enum logic {
    RD_IDLE,
    RD_BURST
  } rd_state_e;

  function automatic int cdt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/autosa_mcif_rd_outbuf.sv
// Two-entry valid/ready response buffer; head entry on out_data.
// Ports: clk/rst_n, in_valid/in_data push, out_valid/out_ready/out_data, count.
module autosa_mcif_rd_outbuf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] d0_q, d0_d;
  logic [W-1:0] d1_q, d1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;
  logic [1:0]   slot;

  assign pop = out_ready & (cnt_q != 2'd0);
  assign slot = cnt_q - 2'(pop);

  always_comb begin
    d0_d  = d0_q;
    d1_d  = d1_q;
    cnt_d = cnt_q + 2'(in_valid) - 2'(pop);
    if (pop) d0_d = d1_q;
    if (in_valid) begin
      if (slot == 2'd0) d0_d = in_data;
      else              d1_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d0_q  <= '0;
      d1_q  <= '0;
      cnt_q <= '0;
    end else begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = cnt_q != 2'd0;
  assign out_data  = d0_q;
  assign count     = cnt_q;

endmodule

// File: rtl/autosa_mcif_sdp_rd_rsp.sv
// SDP read responder: queues burst requests, reads backing memory, returns beats.
// Ports: sdp2mcif_rd_req_*, mcif2sdp_rd_rsp_*, credit pop, mem_rd_*, rd_err, idle.
// Optional range check enabled by AUTOSA_MCIF_RD_RANGE_CHK_EN.
module autosa_mcif_sdp_rd_rsp
  import autosa_mcif_pkg::*;
#(
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int LAT_FIFO_DEPTH = 16,
  parameter int MEM_AW         = 12
) (
  input  logic                autosa_core_clk,
  input  logic                autosa_core_rstn,
  input  logic                sdp2mcif_rd_req_valid,
  output logic                sdp2mcif_rd_req_ready,
  input  logic [REQ_PD_W-1:0] sdp2mcif_rd_req_pd,
  output logic                mcif2sdp_rd_rsp_valid,
  input  logic                mcif2sdp_rd_rsp_ready,
  output logic [RSP_PD_W-1:0] mcif2sdp_rd_rsp_pd,
  input  logic                sdp2mcif_rd_cdt_lat_fifo_pop,
  output logic                mem_rd_en,
  output logic [MEM_AW-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0]   mem_rd_data,
  output logic                rd_err,
  output logic                idle
);

`ifdef AUTOSA_MCIF_RD_RANGE_CHK_EN
  localparam int CUR_W = REQ_ADDR_W - BEAT_SH;
`else
  localparam int CUR_W = MEM_AW;
`endif
  localparam int PW = $clog2(REQ_FIFO_DEPTH);
  localparam int CW = cdt_w(LAT_FIFO_DEPTH);
  localparam logic [CW-1:0] CDT_MAX = CW'(LAT_FIFO_DEPTH);

  logic [CUR_W-1:0]      fa_q [REQ_FIFO_DEPTH];
  logic [REQ_SIZE_W-1:0] fs_q [REQ_FIFO_DEPTH];
  logic [PW:0]           wr_q, wr_d, rd_q, rd_d;
  logic                  f_empty, f_full, req_push, pop;
  logic [CUR_W-1:0]      head_addr;
  logic [REQ_SIZE_W-1:0] head_size;

  rd_state_e             state_q, state_d;
  logic [CUR_W-1:0]      cur_q, cur_d, iss_addr;
  logic [REQ_SIZE_W-1:0] rem_q, rem_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  inflight_q, inflight_d;
  logic                  issue, can_issue, iss_oob;
  logic [2:0]            occ;

  logic                  ob_pop;
  logic [1:0]            ob_count;
  logic [DATA_W-1:0]     ob_in_data, ob_data;
  logic                  unused_ok;

  assign f_empty   = wr_q == rd_q;
  assign f_full    = (wr_q[PW] != rd_q[PW]) &&
                     (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign req_push  = sdp2mcif_rd_req_valid & ~f_full;
  assign head_addr = fa_q[rd_q[PW-1:0]];
  assign head_size = fs_q[rd_q[PW-1:0]];
  assign sdp2mcif_rd_req_ready = ~f_full;

  always_ff @(posedge autosa_core_clk) begin
    if (req_push) begin
      fa_q[wr_q[PW-1:0]] <=
        sdp2mcif_rd_req_pd[REQ_ADDR_LSB+BEAT_SH +: CUR_W];
      fs_q[wr_q[PW-1:0]] <=
        sdp2mcif_rd_req_pd[REQ_SIZE_LSB +: REQ_SIZE_W];
    end
  end

  // The slot freed by this cycle's pop counts as free,
  // so a streaming consumer sees one beat per cycle.
  assign ob_pop = mcif2sdp_rd_rsp_valid & mcif2sdp_rd_rsp_ready;
  assign occ = {1'b0, ob_count} + {2'b0, inflight_q} - {2'b0, ob_pop};
  assign can_issue = (credit_q != '0) && (occ < 3'd2);

  // IDLE issues the head's first beat in the cycle it pops;
  // the last beat of a burst pops the next request.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rem_d    = rem_q;
    pop      = 1'b0;
    issue    = 1'b0;
    iss_addr = cur_q;
    unique case (state_q)
      RD_IDLE: begin
        if (!f_empty && can_issue) begin
          pop      = 1'b1;
          issue    = 1'b1;
          iss_addr = head_addr;
          cur_d    = head_addr + CUR_W'(1);
          rem_d    = head_size - REQ_SIZE_W'(1);
          if (head_size != '0) state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (can_issue) begin
          issue = 1'b1;
          if (rem_q == '0) begin
            if (!f_empty) begin
              pop   = 1'b1;
              cur_d = head_addr;
              rem_d = head_size;
            end else begin
              state_d = RD_IDLE;
            end
          end else begin
            cur_d = cur_q + CUR_W'(1);
            rem_d = rem_q - REQ_SIZE_W'(1);
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_d       = wr_q + (PW+1)'(req_push);
    rd_d       = rd_q + (PW+1)'(pop);
    inflight_d = issue;
    unique case ({issue, sdp2mcif_rd_cdt_lat_fifo_pop})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01:   credit_d = (credit_q == CDT_MAX) ?
                          credit_q : credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge autosa_core_clk) begin
    if (!autosa_core_rstn) begin
      state_q    <= RD_IDLE;
      cur_q      <= '0;
      rem_q      <= '0;
      credit_q   <= CDT_MAX;
      inflight_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      credit_q   <= credit_d;
      inflight_q <= inflight_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  a_cdt_ovf: assert property (
    @(posedge autosa_core_clk) disable iff (!autosa_core_rstn)
    !(sdp2mcif_rd_cdt_lat_fifo_pop && credit_q == CDT_MAX));

`ifdef AUTOSA_MCIF_RD_RANGE_CHK_EN
  logic oob_inf_q, oob_inf_d, err_q, err_d;

  assign iss_oob = |iss_addr[CUR_W-1:MEM_AW];

  always_comb begin
    oob_inf_d = issue & iss_oob;
    err_d     = err_q | oob_inf_d;
  end

  always_ff @(posedge autosa_core_clk) begin
    if (!autosa_core_rstn) begin
      oob_inf_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      oob_inf_q <= oob_inf_d;
      err_q     <= err_d;
    end
  end

  // Out-of-range beats keep their slot and latency but carry zero data.
  assign ob_in_data = oob_inf_q ? '0 : mem_rd_data;
  assign rd_err     = err_q;
  assign unused_ok  = ^sdp2mcif_rd_req_pd[BEAT_SH-1:0];
`else
  assign iss_oob    = 1'b0;
  assign ob_in_data = mem_rd_data;
  assign rd_err     = 1'b0;
  assign unused_ok  = ^{
    sdp2mcif_rd_req_pd[REQ_ADDR_W-1:MEM_AW+BEAT_SH],
    sdp2mcif_rd_req_pd[BEAT_SH-1:0]};
`endif

  assign mem_rd_en   = issue & ~iss_oob;
  assign mem_rd_addr = issue ? iss_addr[MEM_AW-1:0] : '0;

  autosa_mcif_rd_outbuf #(.W(DATA_W)) u_outbuf (
    .clk       (autosa_core_clk),
    .rst_n     (autosa_core_rstn),
    .in_valid  (inflight_q),
    .in_data   (ob_in_data),
    .out_valid (mcif2sdp_rd_rsp_valid),
    .out_ready (mcif2sdp_rd_rsp_ready),
    .out_data  (ob_data),
    .count     (ob_count)
  );

  assign mcif2sdp_rd_rsp_pd = mcif2sdp_rd_rsp_valid ?
                              {1'b1, ob_data} : '0;

  assign idle = f_empty && state_q == RD_IDLE &&
                !inflight_q && ob_count == 2'd0;

endmodule

// File: tb/tb_autosa_mcif_sdp_rd_rsp.sv
// Directed bench for autosa_mcif_sdp_rd_rsp.
// Second instance runs with four latency credits.
module tb_autosa_mcif_sdp_rd_rsp;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [46:0] req_pd;
  logic [64:0] rsp_pd;
  logic        cdt_pop, mem_en, rd_err, idle;
  logic [11:0] mem_addr;
  logic [63:0] mem_data;

  logic        req4_valid, req4_ready, rsp4_valid, rsp4_ready;
  logic [46:0] req4_pd;
  logic [64:0] rsp4_pd;
  logic        pop4, mem4_en, rd_err4, idle4;
  logic [11:0] mem4_addr;
  logic [63:0] mem4_data;

  autosa_mcif_sdp_rd_rsp dut (
    .autosa_core_clk              (clk),
    .autosa_core_rstn             (rstn),
    .sdp2mcif_rd_req_valid        (req_valid),
    .sdp2mcif_rd_req_ready        (req_ready),
    .sdp2mcif_rd_req_pd           (req_pd),
    .mcif2sdp_rd_rsp_valid        (rsp_valid),
    .mcif2sdp_rd_rsp_ready        (rsp_ready),
    .mcif2sdp_rd_rsp_pd           (rsp_pd),
    .sdp2mcif_rd_cdt_lat_fifo_pop (cdt_pop),
    .mem_rd_en                    (mem_en),
    .mem_rd_addr                  (mem_addr),
    .mem_rd_data                  (mem_data),
    .rd_err                       (rd_err),
    .idle                         (idle)
  );

  autosa_mcif_sdp_rd_rsp #(.LAT_FIFO_DEPTH(4)) dut4 (
    .autosa_core_clk              (clk),
    .autosa_core_rstn             (rstn),
    .sdp2mcif_rd_req_valid        (req4_valid),
    .sdp2mcif_rd_req_ready        (req4_ready),
    .sdp2mcif_rd_req_pd           (req4_pd),
    .mcif2sdp_rd_rsp_valid        (rsp4_valid),
    .mcif2sdp_rd_rsp_ready        (rsp4_ready),
    .mcif2sdp_rd_rsp_pd           (rsp4_pd),
    .sdp2mcif_rd_cdt_lat_fifo_pop (pop4),
    .mem_rd_en                    (mem4_en),
    .mem_rd_addr                  (mem4_addr),
    .mem_rd_data                  (mem4_data),
    .rd_err                       (rd_err4),
    .idle                         (idle4)
  );

  function automatic logic [63:0] mem_word(input logic [11:0] a);
    if (a == 12'h010) return {8{8'hA5}};
    return {32'hD00DF00D, 20'h0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en)  mem_data  <= mem_word(mem_addr);
    if (mem4_en) mem4_data <= mem_word(mem4_addr);
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [11:0] iss_a[$];
  int          iss_c[$];
  logic [64:0] bt_d[$];
  int          bt_c[$];
  int          i4_c[$];
  logic        hold_v = 1'b0;
  logic [64:0] hold_pd;

  always @(negedge clk) begin
    if (mem_en) begin
      iss_a.push_back(mem_addr);
      iss_c.push_back(cyc);
    end
    if (rsp_valid && rsp_ready) begin
      bt_d.push_back(rsp_pd);
      bt_c.push_back(cyc);
    end
    if (hold_v) chk("pd_hold", {rsp_valid, rsp_pd}, {1'b1, hold_pd});
    hold_v  = rsp_valid && !rsp_ready && rstn;
    hold_pd = rsp_pd;
    if (mem4_en) i4_c.push_back(cyc);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_a.delete();
    iss_c.delete();
    bt_d.delete();
    bt_c.delete();
  endtask

  task automatic send_req(input logic [31:0] a,
                          input logic [14:0] s,
                          output int t);
    int n = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_pd    = {s, a};
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("req_timeout", 0, 1);
    t = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_pd    = '0;
  endtask

  task automatic pops(input int n);
    @(posedge clk);
    #1;
    cdt_pop = 1'b1;
    wait_cyc(n);
    cdt_pop = 1'b0;
  endtask

  logic [11:0] exp5 [12] = '{12'h40, 12'h41, 12'h42, 12'h43,
                            12'h50, 12'h51, 12'h60, 12'h61,
                            12'h70, 12'h71, 12'h80, 12'h81};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t, p;
    req_valid  = 1'b0;
    req_pd     = '0;
    rsp_ready  = 1'b1;
    cdt_pop    = 1'b0;
    req4_valid = 1'b0;
    req4_pd    = '0;
    rsp4_ready = 1'b1;
    pop4       = 1'b0;
    rstn       = 1'b0;
    wait_cyc(3);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_pd", rsp_pd, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_err", rd_err, 0);
    chk("rst_idle", idle, 1);
    @(posedge clk);
    #1 rstn = 1'b1;
    wait_cyc(2);

    // single beat, latency
    clear_logs();
    send_req(32'h80, 15'd0, t);
    wait_cyc(8);
    chk("t1_niss", iss_a.size(), 1);
    if (iss_a.size() == 1) begin
      chk("t1_addr", iss_a[0], 12'h010);
      chk("t1_iss_cyc", iss_c[0], t + 1);
    end
    chk("t1_nbeat", bt_d.size(), 1);
    if (bt_d.size() == 1) begin
      chk("t1_pd", bt_d[0], {1'b1, {8{8'hA5}}});
      chk("t1_rsp_cyc", bt_c[0], t + 3);
    end
    @(negedge clk);
    chk("t1_idle", idle, 1);
    pops(1);

    // 8-beat burst
    clear_logs();
    send_req(32'h0, 15'd7, t);
    wait_cyc(14);
    chk("t2_niss", iss_a.size(), 8);
    chk("t2_nbeat", bt_d.size(), 8);
    if (iss_a.size() == 8 && bt_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t2_addr", iss_a[i], i);
        chk("t2_iss_cyc", iss_c[i], t + 1 + i);
        chk("t2_pd", bt_d[i], {1'b1, mem_word(12'(i))});
        chk("t2_rsp_cyc", bt_c[i], t + 3 + i);
      end
    end
    chk("t2_cdt8", dut.credit_q, 8);
    pops(8);
    chk("t2_cdt16", dut.credit_q, 16);

    // four credits only
    req4_valid = 1'b1;
    req4_pd    = {15'd9, 32'h0};
    wait_cyc(1);
    req4_valid = 1'b0;
    wait_cyc(15);
    chk("t3_stall", i4_c.size(), 4);
    pop4 = 1'b1;
    p    = cyc;
    wait_cyc(1);
    pop4 = 1'b0;
    wait_cyc(6);
    chk("t3_one_more", i4_c.size(), 5);
    if (i4_c.size() == 5) chk("t3_resume_cyc", i4_c[4], p + 1);

    // backpressure then toggling ready
    clear_logs();
    rsp_ready = 1'b0;
    send_req(32'h100, 15'd15, t);
    wait_cyc(10);
    chk("t4_buf_full", iss_a.size(), 2);
    repeat (60) begin
      rsp_ready = ~rsp_ready;
      wait_cyc(1);
    end
    rsp_ready = 1'b1;
    wait_cyc(5);
    chk("t4_nbeat", bt_d.size(), 16);
    if (bt_d.size() == 16) begin
      for (int i = 0; i < 16; i++)
        chk("t4_pd", bt_d[i], {1'b1, mem_word(12'(32 + i))});
    end
    chk("t4_cdt0", dut.credit_q, 0);
    pops(16);

    // full request FIFO, contiguous bursts
    clear_logs();
    rsp_ready = 1'b0;
    send_req(32'h200, 15'd3, t);
    send_req(32'h280, 15'd1, t);
    send_req(32'h300, 15'd1, t);
    send_req(32'h380, 15'd1, t);
    send_req(32'h400, 15'd1, t);
    @(negedge clk);
    chk("t5_ready_low", req_ready, 0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_cyc(25);
    chk("t5_niss", iss_a.size(), 12);
    chk("t5_nbeat", bt_d.size(), 12);
    if (iss_a.size() == 12 && bt_d.size() == 12) begin
      chk("t5_iss_run", iss_c[11] - iss_c[2], 9);
      chk("t5_rsp_run", bt_c[11] - bt_c[0], 11);
      for (int i = 0; i < 12; i++) begin
        chk("t5_addr", iss_a[i], exp5[i]);
        chk("t5_pd", bt_d[i], {1'b1, mem_word(exp5[i])});
      end
    end

    // address above MEM_AW
    clear_logs();
    send_req(32'h0000_8000, 15'd0, t);
    wait_cyc(8);
    chk("t6_nbeat", bt_d.size(), 1);
`ifdef AUTOSA_MCIF_RD_RANGE_CHK_EN
    chk("t6_niss", iss_a.size(), 0);
    if (bt_d.size() == 1) begin
      chk("t6_pd", bt_d[0], {1'b1, 64'h0});
      chk("t6_rsp_cyc", bt_c[0], t + 3);
    end
    @(negedge clk);
    chk("t6_err", rd_err, 1);
`else
    chk("t6_niss", iss_a.size(), 1);
    if (iss_a.size() == 1) chk("t6_addr", iss_a[0], 0);
    if (bt_d.size() == 1)
      chk("t6_pd", bt_d[0], {1'b1, mem_word(12'h0)});
    @(negedge clk);
    chk("t6_err", rd_err, 0);
`endif

    // reset mid-burst
    clear_logs();
    rsp_ready = 1'b0;
    send_req(32'h0, 15'd15, t);
    wait_cyc(6);
    chk("t7_pre_niss", iss_a.size(), 2);
    rstn = 1'b0;
    wait_cyc(2);
    rstn = 1'b1;
    @(negedge clk);
    chk("t7_idle", idle, 1);
    chk("t7_valid", rsp_valid, 0);
    chk("t7_cdt", dut.credit_q, 16);
    chk("t7_err", rd_err, 0);
    chk("t7_ready", req_ready, 1);
    rsp_ready = 1'b1;
    clear_logs();
    send_req(32'h80, 15'd0, t);
    wait_cyc(8);
    chk("t7_nbeat", bt_d.size(), 1);
    if (bt_d.size() == 1)
      chk("t7_pd", bt_d[0], {1'b1, {8{8'hA5}}});

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
